// File: rtl/me_frame_server_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// me_frame_server_if
// Pixel stream, estimator handshake/read ports and result bus of the frame server.
// Rev 1.0
// ----------------------------------------------------------------------------
interface me_frame_server_if #(
  parameter int PIX_W  = 8,
  parameter int DIST_W = 8,
  parameter int MV_W   = 4
);
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_ready;
  logic              start;
  logic              completed;
  logic [DIST_W-1:0] BestDist;
  logic [MV_W-1:0]   motionX;
  logic [MV_W-1:0]   motionY;
  logic [7:0]        AddressR;
  logic [9:0]        AddressS1;
  logic [9:0]        AddressS2;
  logic [PIX_W-1:0]  R;
  logic [PIX_W-1:0]  S1;
  logic [PIX_W-1:0]  S2;
  logic              res_valid;
  logic              res_ack;
  logic [DIST_W-1:0] res_dist;
  logic [MV_W-1:0]   res_mx;
  logic [MV_W-1:0]   res_my;
  logic              res_err;
  logic [15:0]       frame_cnt;

  modport slave (
    input  pix_valid, pix_data, completed, BestDist, motionX, motionY,
           AddressR, AddressS1, AddressS2, res_ack,
    output pix_ready, start, R, S1, S2, res_valid, res_dist, res_mx, res_my,
           res_err, frame_cnt
  );

  modport master (
    output pix_valid, pix_data, completed, BestDist, motionX, motionY,
           AddressR, AddressS1, AddressS2, res_ack,
    input  pix_ready, start, R, S1, S2, res_valid, res_dist, res_mx, res_my,
           res_err, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/me_frame_server.sv
`default_nettype none
// ----------------------------------------------------------------------------
// me_frame_server
// Loads reference/search memories from a pixel stream, runs the estimator and
// holds its result (or a watchdog abort) until acknowledged.
// Rev 1.0
// ----------------------------------------------------------------------------
module me_frame_server #(
  parameter int PIX_W   = 8,
  parameter int REF_N   = 16,
  parameter int SRCH_N  = 31,
  parameter int DIST_W  = 8,
  parameter int MV_W    = 4,
  parameter int TIMEOUT = 8192
) (
  input  logic               clock,
  input  logic               reset,
  me_frame_server_if.slave   bus
);
  localparam int R_DEPTH   = REF_N * REF_N;
  localparam int S_DEPTH   = SRCH_N * SRCH_N;
  localparam int FRAME_PIX = R_DEPTH + S_DEPTH;
  localparam int CNT_W     = $clog2(FRAME_PIX + 1);
  localparam int WD_W      = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0] C_LAST_PIX = CNT_W'(FRAME_PIX - 1);
  localparam logic [CNT_W-1:0] C_R_DEPTH  = CNT_W'(R_DEPTH);
  localparam logic [WD_W-1:0]  C_WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [9:0]       C_S_DEPTH  = 10'(S_DEPTH);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_pix_cnt;
  logic [WD_W-1:0]    r_wd;
  logic               r_pix_ready;
  logic               r_start;
  logic               r_res_valid;
  logic               r_res_err;
  logic [DIST_W-1:0]  r_res_dist;
  logic [MV_W-1:0]    r_res_mx;
  logic [MV_W-1:0]    r_res_my;
  logic [15:0]        r_frame_cnt;
  logic [PIX_W-1:0]   r_rd_r;
  logic [PIX_W-1:0]   r_rd_s1;
  logic [PIX_W-1:0]   r_rd_s2;

  logic [PIX_W-1:0]   r_mem_r [R_DEPTH];
  logic [PIX_W-1:0]   r_mem_s [S_DEPTH];

  logic               w_beat;
  logic [9:0]         w_s_waddr;

  // pix_ready is only ever high in LOAD, so a beat implies the LOAD state
  assign w_beat    = bus.pix_valid & r_pix_ready;
  assign w_s_waddr = 10'(r_pix_cnt - C_R_DEPTH);

  // Memories are deliberately outside the reset domain: contents survive reset
  always_ff @(posedge clock) begin
    if (w_beat) begin
      if (r_pix_cnt < C_R_DEPTH) begin
        r_mem_r[r_pix_cnt[7:0]] <= bus.pix_data;
      end else begin
        r_mem_s[w_s_waddr] <= bus.pix_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_r  <= '0;
      r_rd_s1 <= '0;
      r_rd_s2 <= '0;
    end else begin
      r_rd_r  <= r_mem_r[bus.AddressR];
      r_rd_s1 <= (bus.AddressS1 < C_S_DEPTH) ? r_mem_s[bus.AddressS1] : '0;
      r_rd_s2 <= (bus.AddressS2 < C_S_DEPTH) ? r_mem_s[bus.AddressS2] : '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_LOAD;
      r_pix_cnt   <= '0;
      r_wd        <= '0;
      r_pix_ready <= 1'b1;
      r_start     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_err   <= 1'b0;
      r_res_dist  <= '0;
      r_res_mx    <= '0;
      r_res_my    <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_beat) begin
            r_pix_cnt <= r_pix_cnt + 1'b1;
            if (r_pix_cnt == C_LAST_PIX) begin
              r_state     <= ST_ARM;
              r_pix_ready <= 1'b0;
            end
          end
        end
        ST_ARM: begin
          r_state <= ST_RUN;
          r_start <= 1'b1;
          r_wd    <= '0;
        end
        ST_RUN: begin
          // completed takes priority over a watchdog expiring on the same cycle
          if (bus.completed) begin
            r_state     <= ST_DONE;
            r_start     <= 1'b0;
            r_res_valid <= 1'b1;
            r_res_err   <= 1'b0;
            r_res_dist  <= bus.BestDist;
            r_res_mx    <= bus.motionX;
            r_res_my    <= bus.motionY;
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end else if (r_wd == C_WD_LAST) begin
            r_state     <= ST_DONE;
            r_start     <= 1'b0;
            r_res_valid <= 1'b1;
            r_res_err   <= 1'b1;
            r_res_dist  <= '1;
            r_res_mx    <= '0;
            r_res_my    <= '0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.res_ack) begin
            r_state     <= ST_LOAD;
            r_res_valid <= 1'b0;
            r_pix_cnt   <= '0;
            r_pix_ready <= 1'b1;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign bus.pix_ready = r_pix_ready;
  assign bus.start     = r_start;
  assign bus.R         = r_rd_r;
  assign bus.S1        = r_rd_s1;
  assign bus.S2        = r_rd_s2;
  assign bus.res_valid = r_res_valid;
  assign bus.res_err   = r_res_err;
  assign bus.res_dist  = r_res_dist;
  assign bus.res_mx    = r_res_mx;
  assign bus.res_my    = r_res_my;
  assign bus.frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_me_frame_server.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_me_frame_server
// Scenario bench: stream loads, read ports, estimator stub, watchdog and reset.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_me_frame_server;
  localparam int PIX_W = 8, DIST_W = 8, MV_W = 4, TIMEOUT = 8192;
  localparam int R_DEPTH = 256, S_DEPTH = 961, FRAME_PIX = 1217;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  me_frame_server_if #(.PIX_W(PIX_W), .DIST_W(DIST_W), .MV_W(MV_W)) bus ();

  me_frame_server #(.PIX_W(PIX_W), .REF_N(16), .SRCH_N(31), .DIST_W(DIST_W),
                    .MV_W(MV_W), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Reference memories, written whenever the bench sees a handshake
  logic [7:0] m_r [R_DEPTH];
  logic [7:0] m_s [S_DEPTH];
  int errors = 0;
  int checks = 0;
  int exp_frames = 0;

  function automatic logic [7:0] exp_s(input int a);
    return (a < S_DEPTH) ? m_s[a] : 8'h00;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_frame(input int data_kind, input int valid_kind, input int n_beats);
    int k = 0;
    int cyc = 0;
    logic v;
    logic [7:0] d;
    while (k < n_beats && cyc < 6000) begin
      case (valid_kind)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      case (data_kind)
        0:       d = 8'h10;
        1:       d = 8'(k * 5 + k / 256);
        default: d = 8'($urandom);
      endcase
      bus.pix_valid = v;
      bus.pix_data  = d;
      if (v && bus.pix_ready === 1'b1) begin
        if (k < R_DEPTH) m_r[k] = d;
        else m_s[k - R_DEPTH] = d;
        k++;
      end
      step();
      cyc++;
    end
    bus.pix_valid = 1'b0;
    checks++;
    if (k != n_beats) begin
      errors++;
      $display("FAIL load_beats: accepted %0d want %0d", k, n_beats);
    end
  endtask

  // After the final beat: one ARM cycle with ready low and start low, then start
  task automatic test_arm();
    checks++;
    if (bus.pix_ready !== 1'b0 || bus.start !== 1'b0) begin
      errors++;
      $display("FAIL arm: pix_ready=%0b start=%0b want 0/0", bus.pix_ready, bus.start);
    end
    step();
    checks++;
    if (bus.start !== 1'b1 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL run_start: start=%0b res_valid=%0b want 1/0", bus.start, bus.res_valid);
    end
  endtask

  task automatic test_complete(input logic [7:0] d, input logic [3:0] mx, input logic [3:0] my);
    bus.completed = 1'b1;
    bus.BestDist  = d;
    bus.motionX   = mx;
    bus.motionY   = my;
    step();
    bus.completed = 1'b0;
    exp_frames++;
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_err !== 1'b0 || bus.start !== 1'b0 ||
        bus.res_dist !== d || bus.res_mx !== mx || bus.res_my !== my ||
        bus.frame_cnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL capture: v=%0b err=%0b start=%0b d=%h mx=%h my=%h fc=%0d want 1/0/0 %h %h %h %0d",
               bus.res_valid, bus.res_err, bus.start, bus.res_dist, bus.res_mx, bus.res_my,
               bus.frame_cnt, d, mx, my, exp_frames);
    end
  endtask

  task automatic test_ack();
    bus.res_ack = 1'b1;
    step();
    bus.res_ack = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.pix_ready !== 1'b1 || bus.frame_cnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL ack: res_valid=%0b pix_ready=%0b fc=%0d want 0/1/%0d",
               bus.res_valid, bus.pix_ready, bus.frame_cnt, exp_frames);
    end
  endtask

  task automatic test_read(input int ar, input int as1, input int as2);
    bus.AddressR  = 8'(ar);
    bus.AddressS1 = 10'(as1);
    bus.AddressS2 = 10'(as2);
    step();
    checks++;
    if (bus.R !== m_r[ar] || bus.S1 !== exp_s(as1) || bus.S2 !== exp_s(as2)) begin
      errors++;
      $display("FAIL read(%0d,%0d,%0d): R=%h S1=%h S2=%h want %h %h %h", ar, as1, as2,
               bus.R, bus.S1, bus.S2, m_r[ar], exp_s(as1), exp_s(as2));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.pix_ready !== 1'b1 || bus.start !== 1'b0 || bus.res_valid !== 1'b0 ||
        bus.res_err !== 1'b0 || bus.res_dist !== 8'h00 || bus.res_mx !== 4'h0 ||
        bus.res_my !== 4'h0 || bus.R !== 8'h00 || bus.S1 !== 8'h00 || bus.S2 !== 8'h00 ||
        bus.frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset: ready=%0b start=%0b v=%0b err=%0b d=%h mx=%h my=%h R=%h S1=%h S2=%h fc=%0d",
               bus.pix_ready, bus.start, bus.res_valid, bus.res_err, bus.res_dist, bus.res_mx,
               bus.res_my, bus.R, bus.S1, bus.S2, bus.frame_cnt);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic_frame();
    load_frame(0, 0, FRAME_PIX);
    test_arm();
    test_read(5, 100, 1000);
    checks++;
    if (bus.start !== 1'b1) begin
      errors++;
      $display("FAIL basic_start_held: start=%0b want 1", bus.start);
    end
    test_complete(8'h00, 4'($urandom), 4'($urandom));
    test_ack();
  endtask

  task automatic test_ramp_reads();
    load_frame(1, 1, FRAME_PIX);
    test_arm();
    // Stream and result ack are driven while running; both must be ignored
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'hA5;
    bus.res_ack   = 1'b1;
    test_read(37, 960, 960);
    test_read(0, 0, 1000);
    test_read(255, 1023, 961);
    for (int i = 0; i < 40; i++)
      test_read(int'($urandom_range(0, 255)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 1023)));
    bus.res_ack = 1'b0;
    checks++;
    if (m_s[0] !== 8'(256 * 5 + 1) || bus.start !== 1'b1 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL run_hold: s0_model=%h start=%0b res_valid=%0b want %h/1/0",
               m_s[0], bus.start, bus.res_valid, 8'(256 * 5 + 1));
    end
    test_complete(8'd42, 4'hE, 4'h3);
    // Further completions in DONE must not disturb the held result
    bus.completed = 1'b1;
    bus.BestDist  = 8'h77;
    bus.motionX   = 4'h1;
    bus.motionY   = 4'h2;
    for (int i = 0; i < 5; i++) begin
      test_read(int'($urandom_range(0, 255)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 1023)));
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_dist !== 8'd42 || bus.res_mx !== 4'hE ||
          bus.res_my !== 4'h3 || bus.start !== 1'b0 || bus.frame_cnt !== 16'(exp_frames)) begin
        errors++;
        $display("FAIL done_hold[%0d]: v=%0b d=%h mx=%h my=%h start=%0b fc=%0d", i,
                 bus.res_valid, bus.res_dist, bus.res_mx, bus.res_my, bus.start, bus.frame_cnt);
      end
    end
    bus.completed = 1'b0;
    bus.pix_valid = 1'b0;
    test_ack();
  endtask

  task automatic test_timeout();
    int n = 0;
    int start_low = 0;
    load_frame(2, 2, FRAME_PIX);
    test_arm();
    while (bus.res_valid !== 1'b1 && n < TIMEOUT + 50) begin
      if (bus.start !== 1'b1) start_low++;
      step();
      n++;
    end
    exp_frames++;
    checks++;
    if (n != TIMEOUT || start_low != 0) begin
      errors++;
      $display("FAIL timeout_len: cycles=%0d start_low=%0d want %0d/0", n, start_low, TIMEOUT);
    end
    checks++;
    if (bus.res_err !== 1'b1 || bus.res_dist !== 8'hFF || bus.res_mx !== 4'h0 ||
        bus.res_my !== 4'h0 || bus.start !== 1'b0 || bus.frame_cnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL timeout_res: err=%0b d=%h mx=%h my=%h start=%0b fc=%0d want 1 ff 0 0 0 %0d",
               bus.res_err, bus.res_dist, bus.res_mx, bus.res_my, bus.start, bus.frame_cnt,
               exp_frames);
    end
    test_ack();
  endtask

  task automatic test_timeout_race();
    load_frame(2, 0, FRAME_PIX);
    test_arm();
    repeat (TIMEOUT - 1) step();
    checks++;
    if (bus.res_valid !== 1'b0 || bus.start !== 1'b1) begin
      errors++;
      $display("FAIL race_pre: res_valid=%0b start=%0b want 0/1", bus.res_valid, bus.start);
    end
    test_complete(8'($urandom_range(0, 254)), 4'($urandom), 4'($urandom));
    test_ack();
  endtask

  task automatic test_reset_midload();
    load_frame(2, 2, 500);
    reset = 1'b1;
    #1;
    exp_frames = 0;
    checks++;
    if (bus.pix_ready !== 1'b1 || bus.start !== 1'b0 || bus.res_valid !== 1'b0 ||
        bus.res_err !== 1'b0 || bus.res_dist !== 8'h00 || bus.frame_cnt !== 16'd0 ||
        bus.R !== 8'h00) begin
      errors++;
      $display("FAIL midload_reset: ready=%0b start=%0b v=%0b err=%0b d=%h fc=%0d R=%h",
               bus.pix_ready, bus.start, bus.res_valid, bus.res_err, bus.res_dist,
               bus.frame_cnt, bus.R);
    end
    step();
    reset = 1'b0;
    // Memory survives reset: earlier and partial-load data must still read back
    for (int i = 0; i < 6; i++)
      test_read(int'($urandom_range(0, 255)), int'($urandom_range(0, 960)),
                int'($urandom_range(0, 960)));
    load_frame(2, 2, FRAME_PIX);
    test_arm();
    test_read(int'($urandom_range(0, 255)), 0, 960);
    test_complete(8'($urandom), 4'($urandom), 4'($urandom));
    test_ack();
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.completed = 1'b0;
    bus.BestDist  = '0;
    bus.motionX   = '0;
    bus.motionY   = '0;
    bus.AddressR  = '0;
    bus.AddressS1 = '0;
    bus.AddressS2 = '0;
    bus.res_ack   = 1'b0;
    test_reset();
    test_basic_frame();
    test_ramp_reads();
    test_timeout();
    test_timeout_race();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "time budget exceeded");
  end

endmodule
`default_nettype wire
